cmp_scan_ctrl: RTL and testbench

Sequencer for the threshold-comparator datapath in the radar STFT detection chain. Accepts magnitude bins from the STFT stage, drives the comparator's clear/enable/stage/count controls so each bin is compared against its threshold-ROM entry, and repeats the frame scan for every detection stage. It collects the registered 1-bit comparator decisions into packed words and signals frame completion to the downstream classifier interface.

---
 rtl/cmp_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cmp_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_scan_ctrl.sv
// Scan sequencer for the STFT threshold comparator: per-stage frame scan, decision packing, run completion.
// Define CMP_HITCNT_EN to build the per-stage hit counter driving oHITS/oHITS_VLD.
module cmp_scan_ctrl #(
  parameter int unsigned IL        = 10,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned NSTAGE    = 5,
  parameter int unsigned WW        = 16
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic          iVLD,
  output logic          oRDY,
  output logic          oCLR,
  output logic          oEN,
  output logic [2:0]    oSTAGE,
  output logic [16:0]   oCNT,
  input  logic          iCMP,
  output logic [WW-1:0] oWORD,
  output logic          oWORD_VLD,
  output logic          oBUSY,
  output logic          oDONE,
  output logic [16:0]   oHITS,
  output logic          oHITS_VLD
);

  localparam int unsigned CW = 17;
  localparam int unsigned SW = 3;
  localparam int unsigned BW = (WW > 1) ? $clog2(WW) : 1;

  if (IL == 0 || WW < 2 || FRAME_LEN == 0 || FRAME_LEN > 131072 || (FRAME_LEN % WW) != 0 ||
      NSTAGE == 0 || NSTAGE > 8) begin : g_bad_cfg
    $error("cmp_scan_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] bin_q;
  logic [SW-1:0] stage_q;
  logic          clr_q, rdy_q, busy_q, done_q;
  logic          en_dly_q;
  logic [BW-1:0] bitcnt_q;
  logic [WW-1:0] sr_q, word_q, sr_nxt_c;
  logic          word_vld_q;
  logic          last_bin_c, last_stage_c;

  assign oEN          = iVLD & rdy_q;
  assign last_bin_c   = (bin_q == CW'(FRAME_LEN - 1));
  assign last_stage_c = (stage_q == SW'(NSTAGE - 1));

  assign oRDY      = rdy_q;
  assign oCLR      = clr_q;
  assign oSTAGE    = stage_q;
  assign oCNT      = bin_q;
  assign oWORD     = word_q;
  assign oWORD_VLD = word_vld_q;
  assign oBUSY     = busy_q;
  assign oDONE     = done_q;

  // Decision lands at its bin position within the current group.
  always_comb begin
    sr_nxt_c           = sr_q;
    sr_nxt_c[bitcnt_q] = iCMP;
  end

  // Sequencer and decision packer; CLEAR arms below override the capture path.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      stage_q    <= '0;
      clr_q      <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_dly_q   <= 1'b0;
      bitcnt_q   <= '0;
      sr_q       <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      word_vld_q <= 1'b0;
      en_dly_q   <= oEN;

      if (en_dly_q) begin
        if (bitcnt_q == BW'(WW - 1)) begin
          word_q     <= sr_nxt_c;
          word_vld_q <= 1'b1;
          sr_q       <= '0;
          bitcnt_q   <= '0;
        end else begin
          sr_q     <= sr_nxt_c;
          bitcnt_q <= bitcnt_q + BW'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          bin_q   <= '0;
          stage_q <= '0;
          if (iSTART) begin
            state_q <= S_CLEAR;
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          bin_q    <= '0;
          sr_q     <= '0;
          bitcnt_q <= '0;
          rdy_q    <= 1'b1;
          state_q  <= S_SCAN;
        end
        S_SCAN: begin
          if (oEN) begin
            if (last_bin_c) begin
              rdy_q   <= 1'b0;
              state_q <= S_DRAIN;
            end else begin
              bin_q <= bin_q + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (last_stage_c) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            stage_q <= stage_q + SW'(1);
            clr_q   <= 1'b1;
            state_q <= S_CLEAR;
          end
        end
        S_DONE: begin
          stage_q <= '0;
          bin_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CMP_HITCNT_EN
  logic [CW-1:0] hit_cnt_q, hits_q, hit_nxt_c;
  logic          hits_vld_q;

  assign hit_nxt_c = hit_cnt_q + CW'(en_dly_q & iCMP);
  assign oHITS     = hits_q;
  assign oHITS_VLD = hits_vld_q;

  // DRAIN holds the stage's final decision, so the total is published from that cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hit_cnt_q  <= '0;
      hits_q     <= '0;
      hits_vld_q <= 1'b0;
    end else begin
      hits_vld_q <= 1'b0;
      hit_cnt_q  <= (state_q == S_CLEAR) ? '0 : hit_nxt_c;
      if (state_q == S_DRAIN) begin
        hits_q     <= hit_nxt_c;
        hits_vld_q <= 1'b1;
      end
    end
  end
`else
  assign oHITS     = '0;
  assign oHITS_VLD = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Scoreboard bench for cmp_scan_ctrl (FRAME_LEN=32, NSTAGE=3, WW=16); expectations are queued per run.
module tb_cmp_scan_ctrl;

  localparam int unsigned FL = 32;
  localparam int unsigned NS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        vld = 1'b0;
  logic        cmp = 1'b0;
  logic        rdy, clr, en, word_vld, busy, done, hits_vld;
  logic [2:0]  stage;
  logic [16:0] cnt, hits;
  logic [15:0] word;

  int          vec = 0;
  int          mis = 0;
  int          mode = 0;
  bit          vld_toggle = 1'b0;
  logic [15:0] exp_word_q[$];
  int          exp_stage_q[$];
  int          exp_hits_q[$];
  int          exp_done = 0;
  int          exp_cnt = 0;
  int          cur_stage = 0;
  int          cyc = 0;
  int          clr_cyc = 0;
  logic        pend_cmp = 1'b0;

  cmp_scan_ctrl #(.IL(10), .FRAME_LEN(FL), .NSTAGE(NS), .WW(16)) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iVLD(vld), .oRDY(rdy), .oCLR(clr), .oEN(en),
    .oSTAGE(stage), .oCNT(cnt), .iCMP(cmp), .oWORD(word), .oWORD_VLD(word_vld), .oBUSY(busy),
    .oDONE(done), .oHITS(hits), .oHITS_VLD(hits_vld)
  );

  always #5 clk = ~clk;

  function automatic logic pat(input int m, input logic [16:0] b);
    case (m)
      0:       pat = ~b[0];
      1:       pat = 1'b1;
      default: pat = (b < 17'd4);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    vec++;
    mis++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  // Source and comparator model: decision for an accepted bin appears the cycle after oEN.
  always @(posedge clk) begin
    #1;
    vld = vld_toggle ? ~vld : 1'b1;
    cmp = pend_cmp;
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin
    cyc++;
    pend_cmp = en ? pat(mode, cnt) : 1'b0;
    if (!vld) chk("en_without_vld", 32'(en), 32'd0);
    if (clr || done || !busy) chk("en_outside_scan", 32'(en), 32'd0);
    if (clr) begin
      if (exp_stage_q.size() == 0) unexpected("clr");
      else begin
        cur_stage = exp_stage_q.pop_front();
        chk("clr_stage", 32'(stage), 32'(cur_stage));
      end
      exp_cnt = 0;
      if (stage == 3'd0) clr_cyc = cyc;
    end
    if (en) begin
      chk("cnt", 32'(cnt), 32'(exp_cnt));
      chk("scan_stage", 32'(stage), 32'(cur_stage));
      exp_cnt++;
    end
    if (word_vld) begin
      if (exp_word_q.size() == 0) unexpected("word_vld");
      else chk("word", 32'(word), 32'(exp_word_q.pop_front()));
    end
    if (hits_vld) begin
      if (exp_hits_q.size() == 0) unexpected("hits_vld");
      else chk("hits", 32'(hits), 32'(exp_hits_q.pop_front()));
    end
    if (done) begin
      if (exp_done == 0) unexpected("done");
      else begin
        exp_done--;
        if (!vld_toggle) chk("run_len", 32'(cyc - clr_cyc + 1), 32'(NS * (FL + 2) + 1));
`ifndef CMP_HITCNT_EN
        chk("hits_tied", {14'd0, hits_vld, hits}, 32'd0);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stage(input int s, input logic [15:0] w0, input logic [15:0] w1, input int h);
    exp_stage_q.push_back(s);
    exp_word_q.push_back(w0);
    exp_word_q.push_back(w1);
`ifdef CMP_HITCNT_EN
    exp_hits_q.push_back(h);
`else
    if (h < 0) exp_hits_q.push_back(h);
`endif
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("start_clr", 32'(clr), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rdy_low", 32'(rdy), 32'd0);
    @(negedge clk);
    chk("start_rdy", 32'(rdy), 32'd1);
    tick();
  endtask

  task automatic wait_done(input int budget, input bit poke);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        if (poke) begin
          start = 1'b1;
          tick();
          start = 1'b0;
        end
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_drained(input string tag);
    repeat (4) tick();
    chk({tag, "_words_left"}, 32'(exp_word_q.size()), 32'd0);
    chk({tag, "_stages_left"}, 32'(exp_stage_q.size()), 32'd0);
    chk({tag, "_hits_left"}, 32'(exp_hits_q.size()), 32'd0);
    chk({tag, "_done_left"}, 32'(exp_done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"}, 32'(rdy), 32'd0);
    chk({tag, "_clr"}, 32'(clr), 32'd0);
    chk({tag, "_en"}, 32'(en), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt), 32'd0);
    chk({tag, "_stage"}, 32'(stage), 32'd0);
    chk({tag, "_word"}, 32'(word), 32'd0);
    chk({tag, "_word_vld"}, 32'(word_vld), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_hits"}, {14'd0, hits_vld, hits}, 32'd0);
  endtask

  initial begin
    bit hit = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_vals("reset");
    tick();
    rst = 1'b0;
    tick();

    // Even bins decide 1, continuous source.
    mode = 0;
    vld_toggle = 1'b0;
    for (int s = 0; s < NS; s++) push_stage(s, 16'h5555, 16'h5555, 16);
    exp_done = 1;
    start_run();
    wait_done(1000, 1'b0);
    check_drained("cont");

    // Same pattern with a gapped source; stray starts in SCAN and DONE.
    mode = 0;
    vld_toggle = 1'b1;
    for (int s = 0; s < NS; s++) push_stage(s, 16'h5555, 16'h5555, 16);
    exp_done = 1;
    start_run();
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1000, 1'b1);
    check_drained("gapped");

    // Reset at bin 20 of stage 1; bins 0..3 decide 1.
    mode = 2;
    vld_toggle = 1'b0;
    exp_stage_q.push_back(0);
    exp_word_q.push_back(16'h000F);
    exp_word_q.push_back(16'h0000);
`ifdef CMP_HITCNT_EN
    exp_hits_q.push_back(4);
`endif
    exp_stage_q.push_back(1);
    exp_word_q.push_back(16'h000F);
    start_run();
    for (int i = 0; i < 200 && !hit; i++) begin
      if (stage == 3'd1 && cnt == 17'd20) hit = 1'b1;
      else tick();
    end
    chk("reached_bin20", 32'(hit), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun");
    check_drained("midrun");

    // All decisions 1 after the aborted run.
    mode = 1;
    for (int s = 0; s < NS; s++) push_stage(s, 16'hFFFF, 16'hFFFF, 32);
    exp_done = 1;
    start_run();
    wait_done(1000, 1'b0);
    check_drained("ones");

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
